// File: rtl/char_pkg.sv
// char_pkg: shared constants and slot record for the falling-character game.
package char_pkg;
   localparam int SLOTS = 8;
   localparam logic [8:0] BOTTOM = 9'd460;
   localparam logic [7:0] ASCII_A = 8'd65;
   typedef struct packed {
      logic       active;
      logic [7:0] ch;
      logic [2:0] speed;
      logic [8:0] x;
      logic [9:0] y;
   } slot_t;
endpackage

// File: rtl/char_match_select.sv
// char_match_select: picks the lowest active slot matching key_ch (largest x, lowest index on ties).
module char_match_select import char_pkg::*; #(
   parameter int N = SLOTS,
   localparam int IW = $clog2(N)
) (
   input  slot_t [N-1:0] slots,
   input  logic [7:0]    key_ch,
   output logic          found,
   output logic [IW-1:0] idx
);
   logic [8:0] best;
   // Strict greater-than keeps the earlier (lower) index on equal x.
   always_comb begin
      found = 1'b0;
      idx = '0;
      best = '0;
      for (int i = 0; i < N; i++)
         if (slots[i].active && slots[i].ch == key_ch && (!found || slots[i].x > best)) begin
            found = 1'b1;
            idx = IW'(i);
            best = slots[i].x;
         end
   end
endmodule

// File: rtl/char_catcher.sv
// char_catcher: tracks falling characters, advances them per frame, scores keypress hits
// and counts characters that reach the bottom row.
module char_catcher import char_pkg::*; #(
   parameter int SLOTS = char_pkg::SLOTS,
   parameter logic [8:0] BOTTOM = char_pkg::BOTTOM
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        spawn_valid,
   output logic        spawn_ready,
   input  logic [7:0]  ch,
   input  logic [2:0]  speed,
   input  logic [8:0]  x,
   input  logic [9:0]  y,
   input  logic        frame_tick,
   input  logic        key_valid,
   input  logic [7:0]  key_ch,
   input  logic [2:0]  rd_idx,
   output logic        rd_active,
   output logic [7:0]  rd_ch,
   output logic [8:0]  rd_x,
   output logic [9:0]  rd_y,
   output logic        hit_pulse,
   output logic        miss_pulse,
   output logic [15:0] score,
   output logic [7:0]  misses,
   output logic [3:0]  active_count
);
   localparam int IW = $clog2(SLOTS);
   slot_t [SLOTS-1:0] slots, slots_nxt;
   slot_t rd_slot;
   logic found, hit, spawn;
   logic [IW-1:0] hit_idx, spawn_idx;
   logic [3:0] miss_n, count_nxt;
   logic [8:0] miss_sum;

   char_match_select #(.N(SLOTS)) u_sel (
      .slots (slots),
      .key_ch(key_ch),
      .found (found),
      .idx   (hit_idx)
   );

   always_comb begin
      spawn_ready = 1'b0;
      spawn_idx = '0;
      for (int i = SLOTS - 1; i >= 0; i--)
         if (!slots[i].active) begin
            spawn_ready = 1'b1;
            spawn_idx = IW'(i);
         end
   end

   assign spawn = spawn_valid && spawn_ready;
   assign hit = key_valid && found;

   // Spawn target was inactive at cycle start, so it never collides with a slot freed this cycle.
   always_comb begin
      slots_nxt = slots;
      miss_n = '0;
      count_nxt = '0;
      for (int i = 0; i < SLOTS; i++) begin
         if (hit && hit_idx == IW'(i))
            slots_nxt[i] = '0;
         else if (frame_tick && slots[i].active) begin
            if ({1'b0, slots[i].x} + 10'(slots[i].speed) >= 10'(BOTTOM)) begin
               slots_nxt[i] = '0;
               miss_n = miss_n + 4'd1;
            end else
               slots_nxt[i].x = slots[i].x + 9'(slots[i].speed);
         end
         if (spawn && spawn_idx == IW'(i))
            slots_nxt[i] = {1'b1, ch, speed, x, y};
         count_nxt = count_nxt + 4'(slots_nxt[i].active);
      end
   end

   assign miss_sum = {1'b0, misses} + 9'(miss_n);

   always_ff @(posedge clk) begin
      if (rst) begin
         slots <= '0;
         score <= '0;
         misses <= '0;
         active_count <= '0;
         hit_pulse <= 1'b0;
         miss_pulse <= 1'b0;
      end else begin
         slots <= slots_nxt;
         score <= (hit && score != 16'hFFFF) ? score + 16'd1 : score;
         misses <= miss_sum[8] ? 8'hFF : miss_sum[7:0];
         active_count <= count_nxt;
         hit_pulse <= hit;
         miss_pulse <= miss_n != 4'd0;
      end
   end

   assign rd_slot = slots[rd_idx];
   assign rd_active = rd_slot.active;
   assign rd_ch = rd_slot.active ? rd_slot.ch : 8'd0;
   assign rd_x = rd_slot.active ? rd_slot.x : 9'd0;
   assign rd_y = rd_slot.active ? rd_slot.y : 10'd0;
endmodule

// File: tb/tb_char_catcher.sv
// tb_char_catcher: directed scenario tasks with hand-computed expectations for char_catcher.
module tb_char_catcher;
   import char_pkg::*;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic spawn_valid = 1'b0, spawn_ready;
   logic [7:0] ch = '0;
   logic [2:0] speed = '0;
   logic [8:0] x = '0;
   logic [9:0] y = '0;
   logic frame_tick = 1'b0, key_valid = 1'b0;
   logic [7:0] key_ch = '0;
   logic [2:0] rd_idx = '0;
   logic rd_active, hit_pulse, miss_pulse;
   logic [7:0] rd_ch, misses;
   logic [8:0] rd_x;
   logic [9:0] rd_y;
   logic [15:0] score;
   logic [3:0] active_count;
   int n_checks = 0, n_fail = 0;

   char_catcher dut (
      .clk(clk), .rst(rst), .spawn_valid(spawn_valid), .spawn_ready(spawn_ready),
      .ch(ch), .speed(speed), .x(x), .y(y), .frame_tick(frame_tick),
      .key_valid(key_valid), .key_ch(key_ch), .rd_idx(rd_idx), .rd_active(rd_active),
      .rd_ch(rd_ch), .rd_x(rd_x), .rd_y(rd_y), .hit_pulse(hit_pulse),
      .miss_pulse(miss_pulse), .score(score), .misses(misses), .active_count(active_count)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic spawn(input logic [7:0] c, input logic [2:0] s, input logic [8:0] px, input logic [9:0] py);
      ch = c; speed = s; x = px; y = py; spawn_valid = 1'b1;
      step();
      spawn_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; spawn_valid = 1'b1; ch = 8'd65; x = 9'd5; key_valid = 1'b1; key_ch = 8'd65; frame_tick = 1'b1;
      step();
      rst = 1'b0; spawn_valid = 1'b0; key_valid = 1'b0; frame_tick = 1'b0; rd_idx = 3'd0;
      n_checks++; if (active_count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", active_count); end
      n_checks++; if (rd_active !== 1'b0) begin n_fail++; $display("FAIL reset_active: got %0d want 0", rd_active); end
      n_checks++; if (score !== 16'd0 || misses !== 8'd0) begin n_fail++; $display("FAIL reset_score: got %0d/%0d want 0/0", score, misses); end
      n_checks++; if (hit_pulse !== 1'b0 || miss_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: got %0d/%0d want 0/0", hit_pulse, miss_pulse); end
      n_checks++; if (spawn_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0d want 1", spawn_ready); end
   endtask

   task automatic test_spawn_read();
      do_reset();
      spawn(ASCII_A, 3'd3, 9'd0, 10'd99);
      rd_idx = 3'd0;
      #1;
      n_checks++; if (active_count !== 4'd1) begin n_fail++; $display("FAIL spawn_count: got %0d want 1", active_count); end
      n_checks++; if ({rd_active, rd_ch, rd_x, rd_y} !== {1'b1, 8'd65, 9'd0, 10'd99})
         begin n_fail++; $display("FAIL spawn_read: got a=%0d ch=%0d x=%0d y=%0d want 1/65/0/99", rd_active, rd_ch, rd_x, rd_y); end
   endtask

   task automatic test_hit();
      for (int i = 0; i < 5; i++) begin frame_tick = 1'b1; step(); end
      frame_tick = 1'b0;
      n_checks++; if (rd_x !== 9'd15) begin n_fail++; $display("FAIL advance_x: got %0d want 15", rd_x); end
      key_valid = 1'b1; key_ch = 8'd65;
      step();
      key_valid = 1'b0;
      n_checks++; if (hit_pulse !== 1'b1 || score !== 16'd1) begin n_fail++; $display("FAIL hit: got pulse=%0d score=%0d want 1/1", hit_pulse, score); end
      n_checks++; if (active_count !== 4'd0 || rd_active !== 1'b0 || rd_x !== 9'd0)
         begin n_fail++; $display("FAIL hit_free: got cnt=%0d a=%0d x=%0d want 0/0/0", active_count, rd_active, rd_x); end
      key_valid = 1'b1; key_ch = 8'd90;
      step();
      key_valid = 1'b0;
      n_checks++; if (hit_pulse !== 1'b0 || score !== 16'd1) begin n_fail++; $display("FAIL nomatch_key: got pulse=%0d score=%0d want 0/1", hit_pulse, score); end
   endtask

   task automatic test_miss();
      spawn(8'd66, 3'd3, 9'd457, 10'd1);
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      n_checks++; if (miss_pulse !== 1'b1 || misses !== 8'd1) begin n_fail++; $display("FAIL miss: got pulse=%0d misses=%0d want 1/1", miss_pulse, misses); end
      n_checks++; if (score !== 16'd1 || active_count !== 4'd0) begin n_fail++; $display("FAIL miss_state: got score=%0d cnt=%0d want 1/0", score, active_count); end
      step();
      n_checks++; if (miss_pulse !== 1'b0) begin n_fail++; $display("FAIL miss_pulse_width: got %0d want 0", miss_pulse); end
   endtask

   task automatic test_full();
      do_reset();
      for (int i = 0; i < 8; i++) spawn(8'(65 + i), 3'd1, 9'(10 * i), 10'(i));
      #1;
      n_checks++; if (spawn_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %0d want 0", spawn_ready); end
      ch = 8'd90; speed = 3'd1; x = 9'd300; y = 10'd5; spawn_valid = 1'b1; rd_idx = 3'd3;
      step();
      n_checks++; if (active_count !== 4'd8 || rd_ch !== 8'd68) begin n_fail++; $display("FAIL full_hold: got cnt=%0d ch=%0d want 8/68", active_count, rd_ch); end
      key_valid = 1'b1; key_ch = 8'd68;
      step();
      key_valid = 1'b0;
      n_checks++; if (hit_pulse !== 1'b1 || rd_active !== 1'b0 || spawn_ready !== 1'b1)
         begin n_fail++; $display("FAIL full_free: got pulse=%0d a=%0d rdy=%0d want 1/0/1", hit_pulse, rd_active, spawn_ready); end
      step();
      spawn_valid = 1'b0;
      n_checks++; if (rd_ch !== 8'd90 || rd_x !== 9'd300 || active_count !== 4'd8)
         begin n_fail++; $display("FAIL full_refill: got ch=%0d x=%0d cnt=%0d want 90/300/8", rd_ch, rd_x, active_count); end
   endtask

   task automatic test_coincident();
      do_reset();
      spawn(8'd65, 3'd2, 9'd0, 10'd0);
      spawn(8'd65, 3'd2, 9'd0, 10'd0);
      spawn(8'd67, 3'd2, 9'd100, 10'd0);
      spawn(8'd65, 3'd2, 9'd0, 10'd0);
      spawn(8'd65, 3'd2, 9'd0, 10'd0);
      spawn(8'd67, 3'd2, 9'd200, 10'd0);
      key_valid = 1'b1; key_ch = 8'd67; frame_tick = 1'b1;
      step();
      key_valid = 1'b0; frame_tick = 1'b0; rd_idx = 3'd5;
      #1;
      n_checks++; if (rd_active !== 1'b0 || hit_pulse !== 1'b1 || score !== 16'd1 || miss_pulse !== 1'b0)
         begin n_fail++; $display("FAIL coinc_hit: got a=%0d pulse=%0d score=%0d miss=%0d want 0/1/1/0", rd_active, hit_pulse, score, miss_pulse); end
      rd_idx = 3'd2;
      #1;
      n_checks++; if (rd_x !== 9'd102 || active_count !== 4'd5) begin n_fail++; $display("FAIL coinc_adv: got x=%0d cnt=%0d want 102/5", rd_x, active_count); end
      ch = 8'd69; speed = 3'd4; x = 9'd50; y = 10'd7; spawn_valid = 1'b1; frame_tick = 1'b1;
      step();
      spawn_valid = 1'b0; frame_tick = 1'b0;
      n_checks++; if (rd_x !== 9'd104) begin n_fail++; $display("FAIL coinc_adv2: got %0d want 104", rd_x); end
      rd_idx = 3'd5;
      #1;
      n_checks++; if (rd_ch !== 8'd69 || rd_x !== 9'd50 || active_count !== 4'd6)
         begin n_fail++; $display("FAIL spawn_tick: got ch=%0d x=%0d cnt=%0d want 69/50/6", rd_ch, rd_x, active_count); end
   endtask

   task automatic test_multi_miss_reset();
      do_reset();
      spawn(8'd70, 3'd2, 9'd458, 10'd0);
      spawn(8'd71, 3'd2, 9'd458, 10'd0);
      spawn(8'd72, 3'd0, 9'd10, 10'd3);
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0; rd_idx = 3'd2;
      #1;
      n_checks++; if (misses !== 8'd2 || miss_pulse !== 1'b1 || active_count !== 4'd1)
         begin n_fail++; $display("FAIL multi_miss: got misses=%0d pulse=%0d cnt=%0d want 2/1/1", misses, miss_pulse, active_count); end
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      n_checks++; if (miss_pulse !== 1'b0 || rd_x !== 9'd10 || misses !== 8'd2)
         begin n_fail++; $display("FAIL speed0: got pulse=%0d x=%0d misses=%0d want 0/10/2", miss_pulse, rd_x, misses); end
      rst = 1'b1; key_valid = 1'b1; key_ch = 8'd72; frame_tick = 1'b1;
      step();
      rst = 1'b0; key_valid = 1'b0; frame_tick = 1'b0;
      n_checks++; if (misses !== 8'd0 || active_count !== 4'd0 || rd_active !== 1'b0 || hit_pulse !== 1'b0 || score !== 16'd0)
         begin n_fail++; $display("FAIL mid_reset: got misses=%0d cnt=%0d a=%0d hit=%0d score=%0d want all 0", misses, active_count, rd_active, hit_pulse, score); end
      n_checks++; if (spawn_ready !== 1'b1) begin n_fail++; $display("FAIL mid_reset_ready: got %0d want 1", spawn_ready); end
   endtask

   initial begin
      test_reset();
      test_spawn_read();
      test_hit();
      test_miss();
      test_full();
      test_coincident();
      test_multi_miss_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
